// File: rtl/quadrature_pkg.sv
// Shared state encodings, step codes and the {prev, st} transition classifier
// for the quadrature decoder.
package quadrature_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Up order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B); anything with both bits flipped is illegal.
  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] st);
    step_e code;
    case ({prev, st})
      {ST_00, ST_10}, {ST_10, ST_11}, {ST_11, ST_01}, {ST_01, ST_00}: code = STEP_UP;
      {ST_10, ST_00}, {ST_11, ST_10}, {ST_01, ST_11}, {ST_00, ST_01}: code = STEP_DOWN;
      {ST_00, ST_00}, {ST_10, ST_10}, {ST_11, ST_11}, {ST_01, ST_01}: code = STEP_NONE;
      default:                                                         code = STEP_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/quadrature_glitch_filter.sv
// Single-channel glitch filter: the output follows the input only after it has
// differed from the output for FILTER_CYCLES consecutive samples.
module quadrature_glitch_filter
  import quadrature_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic io_mainClk,
  input  logic io_asyncReset,
  input  logic i_in,
  output logic o_out
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic       r_out;
  logic [7:0] r_cnt;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_out <= 1'b0;
      r_cnt <= 8'd0;
    end else if (i_in == r_out) begin
      r_cnt <= 8'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_out <= i_in;
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/quadrature_decoder.sv
// 4x quadrature decoder: pad synchroniser, priming, decode and signed position count.
// Optional glitch filtering on both channels when QUADRATURE_FILTER_EN is defined.
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             io_mainClk,
  input  logic             io_asyncReset,
  input  logic             io_quadA,
  input  logic             io_quadB,
  input  logic             io_clear,
  input  logic             io_load,
  input  logic [WIDTH-1:0] io_loadValue,
  input  logic             io_errorClear,
  output logic [WIDTH-1:0] io_position,
  output logic             io_direction,
  output logic             io_step,
  output logic             io_error
);

`ifdef QUADRATURE_FILTER_EN
  localparam int PRIME_LAST = 2 + FILTER_CYCLES;
`else
  localparam int PRIME_LAST = 2;
`endif
  localparam int                PRIME_W    = $clog2(PRIME_LAST + 2);
  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(PRIME_LAST);
  localparam logic [PRIME_W-1:0] PRIME_RUN  = PRIME_W'(PRIME_LAST + 1);

  if ((FILTER_CYCLES < 1) || (FILTER_CYCLES > 255) || (WIDTH < 2) || (WIDTH > 32)) begin : g_param_out_of_range
  end

  logic [1:0]         r_syncA;
  logic [1:0]         r_syncB;
  logic [1:0]         r_prev;
  logic [PRIME_W-1:0] r_prime;
  logic [WIDTH-1:0]   r_position;
  logic               r_direction;
  logic               r_step;
  logic               r_error;

  logic [1:0]         w_st;
  logic [1:0]         w_dec_st;
  logic               w_prime_load;
  logic               w_run;
  step_e              w_code;
  logic               w_up;
  logic               w_down;
  logic               w_illegal;
  logic [WIDTH-1:0]   w_pos_next;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_syncA <= 2'b00;
      r_syncB <= 2'b00;
    end else begin
      r_syncA <= {r_syncA[0], io_quadA};
      r_syncB <= {r_syncB[0], io_quadB};
    end
  end

  assign w_st = {r_syncA[1], r_syncB[1]};

`ifdef QUADRATURE_FILTER_EN
  logic w_filtA;
  logic w_filtB;

  quadrature_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .io_mainClk    (io_mainClk),
    .io_asyncReset (io_asyncReset),
    .i_in          (w_st[1]),
    .o_out         (w_filtA)
  );

  quadrature_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .io_mainClk    (io_mainClk),
    .io_asyncReset (io_asyncReset),
    .i_in          (w_st[0]),
    .o_out         (w_filtB)
  );

  assign w_dec_st = {w_filtA, w_filtB};
`else
  assign w_dec_st = w_st;
`endif

  // Priming lets the pipeline fill with the real pin level before prev is captured,
  // so pins sitting at 11 out of reset never look like an illegal 00->11 jump.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_prime <= '0;
    end else if (r_prime != PRIME_RUN) begin
      r_prime <= r_prime + PRIME_W'(1);
    end else begin
      r_prime <= r_prime;
    end
  end

  assign w_prime_load = (r_prime == PRIME_LOAD);
  assign w_run        = (r_prime == PRIME_RUN);

  always_comb begin
    w_code    = decode_step(r_prev, w_dec_st);
    w_up      = 1'b0;
    w_down    = 1'b0;
    w_illegal = 1'b0;
    if (w_run) begin
      w_up      = (w_code == STEP_UP);
      w_down    = (w_code == STEP_DOWN);
      w_illegal = (w_code == STEP_ILLEGAL);
    end else begin
      w_up      = 1'b0;
      w_down    = 1'b0;
      w_illegal = 1'b0;
    end
  end

  // Clear beats load beats a decoded step; the step is still reported on io_step.
  always_comb begin
    w_pos_next = r_position;
    if (io_clear) begin
      w_pos_next = '0;
    end else if (io_load) begin
      w_pos_next = io_loadValue;
    end else if (w_up) begin
      w_pos_next = r_position + WIDTH'(1);
    end else if (w_down) begin
      w_pos_next = r_position - WIDTH'(1);
    end else begin
      w_pos_next = r_position;
    end
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_prev      <= 2'b00;
      r_position  <= '0;
      r_direction <= 1'b0;
      r_step      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_prime_load || w_run) begin
        r_prev <= w_dec_st;
      end
      r_position <= w_pos_next;
      r_step     <= w_up | w_down;
      if (w_up | w_down) begin
        r_direction <= w_up;
      end
      if (w_illegal) begin
        r_error <= 1'b1;
      end else if (io_errorClear) begin
        r_error <= 1'b0;
      end
    end
  end

  assign io_position  = r_position;
  assign io_direction = r_direction;
  assign io_step      = r_step;
  assign io_error     = r_error;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder (WIDTH=16); expected steps are queued
// when pins are driven and matched against io_step pulses as they appear.
module tb_quadrature_decoder;

`ifdef QUADRATURE_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        quad_a;
  logic        quad_b;
  logic        clr;
  logic        load;
  logic [15:0] load_value;
  logic        err_clr;
  logic [15:0] position;
  logic        direction;
  logic        step;
  logic        error;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cycle    = 0;
  logic [15:0] exp_pos  = 16'h0000;
  logic [1:0]  m_pins   = 2'b00;

  always #5 clk = ~clk;

  quadrature_decoder #(.WIDTH(16), .FILTER_CYCLES(4)) dut (
    .io_mainClk    (clk),
    .io_asyncReset (rst),
    .io_quadA      (quad_a),
    .io_quadB      (quad_b),
    .io_clear      (clr),
    .io_load       (load),
    .io_loadValue  (load_value),
    .io_errorClear (err_clr),
    .io_position   (position),
    .io_direction  (direction),
    .io_step       (step),
    .io_error      (error)
  );

  function automatic logic [1:0] up_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (sb_q.size() != 0 && sb_q[0].due < cycle) begin
      n_checks++;
      $display("FAIL missed_step: no io_step seen, required at cycle %0d (now %0d)", sb_q[0].due, cycle);
      void'(sb_q.pop_front());
    end
    if (step !== 1'b0) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_step: io_step=%b at cycle %0d, required 0", step, cycle);
      end else begin
        e = sb_q.pop_front();
        if (position !== e.pos || direction !== e.dir || cycle !== e.due) begin
          $display("FAIL step_result: pos=%h dir=%b cycle=%0d, required pos=%h dir=%b cycle=%0d",
                   position, direction, cycle, e.pos, e.dir, e.due);
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_pins(input logic a, input logic b);
    logic [1:0] to;
    exp_t e;
    to = {a, b};
    if (to != m_pins) begin
      if (to == up_next(m_pins)) begin
        exp_pos = exp_pos + 16'h0001;
        e.pos = exp_pos; e.dir = 1'b1; e.due = cycle + LAT;
        sb_q.push_back(e);
      end else if (m_pins == up_next(to)) begin
        exp_pos = exp_pos - 16'h0001;
        e.pos = exp_pos; e.dir = 1'b0; e.due = cycle + LAT;
        sb_q.push_back(e);
      end
    end
    quad_a = a;
    quad_b = b;
    m_pins = to;
  endtask

  task automatic test_reset();
    rst = 1'b1; quad_a = 1'b1; quad_b = 1'b1; m_pins = 2'b11;
    clr = 1'b0; load = 1'b0; load_value = 16'h0000; err_clr = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (position !== 16'h0000 || direction !== 1'b0 || step !== 1'b0 || error !== 1'b0) begin
      $display("FAIL reset_values: pos=%h dir=%b step=%b err=%b, required 0000 0 0 0", position, direction, step, error);
    end else n_pass++;
    rst = 1'b0;
    exp_pos = 16'h0000;
    wait_cycles(10);
    n_checks++;
    if (error !== 1'b0 || position !== 16'h0000) begin
      $display("FAIL prime_at_11: err=%b pos=%h, required err=0 pos=0000", error, position);
    end else n_pass++;
    drive_pins(1'b0, 1'b1);
    wait_cycles(4);
    drive_pins(1'b0, 1'b0);
    wait_cycles(8);
    n_checks++;
    if (position !== 16'h0002) begin
      $display("FAIL first_steps: pos=%h, required 0002", position);
    end else n_pass++;
    clr = 1'b1; tick(); clr = 1'b0; tick();
    exp_pos = 16'h0000;
    n_checks++;
    if (position !== 16'h0000) begin
      $display("FAIL clear: pos=%h, required 0000", position);
    end else n_pass++;
  endtask

  task automatic test_up_cycle();
    drive_pins(1'b1, 1'b0); wait_cycles(4);
    drive_pins(1'b1, 1'b1); wait_cycles(4);
    drive_pins(1'b0, 1'b1); wait_cycles(4);
    drive_pins(1'b0, 1'b0); wait_cycles(LAT + 3);
    n_checks++;
    if (position !== 16'h0004 || direction !== 1'b1 || sb_q.size() != 0) begin
      $display("FAIL up_cycle: pos=%h dir=%b pending=%0d, required 0004 1 0", position, direction, sb_q.size());
    end else n_pass++;
  endtask

  task automatic test_down_cycle();
    clr = 1'b1; tick(); clr = 1'b0; tick();
    exp_pos = 16'h0000;
    drive_pins(1'b0, 1'b1); wait_cycles(4);
    drive_pins(1'b1, 1'b1); wait_cycles(4);
    drive_pins(1'b1, 1'b0); wait_cycles(4);
    drive_pins(1'b0, 1'b0); wait_cycles(LAT + 3);
    n_checks++;
    if (position !== 16'hFFFC || direction !== 1'b0 || sb_q.size() != 0) begin
      $display("FAIL down_cycle: pos=%h dir=%b pending=%0d, required FFFC 0 0", position, direction, sb_q.size());
    end else n_pass++;
  endtask

  task automatic test_error();
    drive_pins(1'b1, 1'b1);
    wait_cycles(LAT + 3);
    n_checks++;
    if (error !== 1'b1 || position !== exp_pos) begin
      $display("FAIL illegal_jump: err=%b pos=%h, required err=1 pos=%h", error, position, exp_pos);
    end else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    n_checks++;
    if (error !== 1'b0) begin
      $display("FAIL error_clear: err=%b, required 0", error);
    end else n_pass++;
    drive_pins(1'b0, 1'b0);
    wait_cycles(LAT - 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    n_checks++;
    if (error !== 1'b1 || position !== exp_pos) begin
      $display("FAIL set_beats_clear: err=%b pos=%h, required err=1 pos=%h", error, position, exp_pos);
    end else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    n_checks++;
    if (error !== 1'b0) begin
      $display("FAIL error_clear2: err=%b, required 0", error);
    end else n_pass++;
  endtask

  task automatic test_load_and_clear();
    load_value = 16'h7FFF; load = 1'b1; tick(); load = 1'b0; tick();
    exp_pos = 16'h7FFF;
    n_checks++;
    if (position !== 16'h7FFF) begin
      $display("FAIL load: pos=%h, required 7FFF", position);
    end else n_pass++;
    drive_pins(1'b1, 1'b0);
    wait_cycles(LAT + 3);
    n_checks++;
    if (position !== 16'h8000) begin
      $display("FAIL load_then_up: pos=%h, required 8000", position);
    end else n_pass++;
    drive_pins(1'b1, 1'b1);
    sb_q[sb_q.size() - 1].pos = 16'h0000;
    exp_pos = 16'h0000;
    wait_cycles(LAT - 1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    n_checks++;
    if (position !== 16'h0000 || direction !== 1'b1 || sb_q.size() != 0) begin
      $display("FAIL step_with_clear: pos=%h dir=%b pending=%0d, required 0000 1 0", position, direction, sb_q.size());
    end else n_pass++;
  endtask

  task automatic test_reset_midop();
    drive_pins(1'b0, 1'b1);
    wait_cycles(LAT + 3);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (position !== 16'h0000 || direction !== 1'b0 || error !== 1'b0) begin
      $display("FAIL async_reset: pos=%h dir=%b err=%b, required 0000 0 0", position, direction, error);
    end else n_pass++;
    exp_pos = 16'h0000;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(10);
    n_checks++;
    if (position !== 16'h0000 || error !== 1'b0) begin
      $display("FAIL reprime_at_01: pos=%h err=%b, required 0000 0", position, error);
    end else n_pass++;
    drive_pins(1'b0, 1'b0);
    wait_cycles(LAT + 3);
    n_checks++;
    if (position !== 16'h0001 || direction !== 1'b1) begin
      $display("FAIL step_after_reset: pos=%h dir=%b, required 0001 1", position, direction);
    end else n_pass++;
  endtask

`ifdef QUADRATURE_FILTER_EN
  task automatic test_filter();
    quad_a = 1'b1;
    wait_cycles(3);
    quad_a = 1'b0;
    wait_cycles(12);
    n_checks++;
    if (position !== exp_pos || error !== 1'b0) begin
      $display("FAIL glitch_ignored: pos=%h err=%b, required %h 0", position, error, exp_pos);
    end else n_pass++;
    drive_pins(1'b1, 1'b0);
    wait_cycles(LAT + 3);
    n_checks++;
    if (position !== exp_pos || direction !== 1'b1) begin
      $display("FAIL filtered_step: pos=%h dir=%b, required %h 1", position, direction, exp_pos);
    end else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_up_cycle();
    test_down_cycle();
    test_error();
    test_load_and_clear();
    test_reset_midop();
`ifdef QUADRATURE_FILTER_EN
    test_filter();
`endif
    wait_cycles(LAT + 2);
    n_checks++;
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
